// File: rtl/uart_char_rx.sv
// 8N1 UART receiver producing ascii_char/char_valid strobes for the sequence checker.
// Framing errors are reported on frame_error and never produce a character strobe.
module uart_char_rx #(
  parameter int UART_RX_BAUD = 20,
  parameter int freq         = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] ascii_char,
  output logic       char_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CPB  = freq / UART_RX_BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_char_rx: freq/UART_RX_BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [1:0]    sync_ok_q, sync_ok_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    char_q, char_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      sync_ok_q <= 2'b00;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      char_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      sync_ok_q <= sync_ok_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      char_q    <= char_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    sync_d    = {sync_q[0], rx};
    sync_ok_d = {sync_ok_q[0], 1'b1};
    // The synchroniser resets to 1, so only trust rx_s once real line data
    // has reached it; a line still low after reset must go high before re-arming.
    armed_d   = armed_q | (sync_ok_q[1] & rx_s);
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    char_d    = char_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (armed_q && !rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            char_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ascii_char  = char_q;
  assign char_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_char_rx.sv
// Directed and randomized bench for uart_char_rx: default rate instance plus a CPB=4 instance.
module tb_uart_char_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] char_a, char_b;
  logic       cv_a, cv_b, fe_a, fe_b, busy_a, busy_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit         inst;
    logic [7:0] val;
    int         at;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  rec_t mon_r;
  int   fe_cnt       = 0;
  int   busy_rises   = 0;
  int   busy_rise_at = 0;
  int   busy_fall_at = 0;
  logic busy_prev    = 1'b0;

  uart_char_rx dut_a (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_a),
    .ascii_char (char_a),
    .char_valid (cv_a),
    .frame_error(fe_a),
    .busy       (busy_a)
  );

  uart_char_rx #(.UART_RX_BAUD(40), .freq(160)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_b),
    .ascii_char (char_b),
    .char_valid (cv_b),
    .frame_error(fe_b),
    .busy       (busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor on the falling edge
  initial forever begin
    @(negedge clk);
    checks++;
    assert (((cv_a & fe_a) | (cv_b & fe_b)) === 1'b0) else begin
      failures++;
      $error("FAIL strobe_excl observed cv_a=%b fe_a=%b cv_b=%b fe_b=%b expected no overlap", cv_a, fe_a, cv_b, fe_b);
    end
    if (cv_a) begin
      mon_r.inst = 1'b0; mon_r.val = char_a; mon_r.at = cyc;
      got_q.push_back(mon_r);
    end
    if (cv_b) begin
      mon_r.inst = 1'b1; mon_r.val = char_b; mon_r.at = cyc;
      got_q.push_back(mon_r);
    end
    if (fe_a) fe_cnt++;
    if (fe_b) fe_cnt++;
    if (busy_a && !busy_prev) begin
      busy_rises++;
      busy_rise_at = cyc;
    end
    if (!busy_a && busy_prev) busy_fall_at = cyc;
    busy_prev = busy_a;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int cycles);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Reference model: a good frame yields its byte one cycle after the stop
  // sample, i.e. 2 sync cycles + 1 detect + HALF + 9 bit times after the pin falls.
  task automatic send(input int cpb, input logic [7:0] val, input logic stop_b, input bit sel);
    logic [9:0] f;
    rec_t       e;
    f = {stop_b, val, 1'b0};
    if (stop_b) begin
      e.inst = sel;
      e.val  = val;
      e.at   = cyc + 3 + cpb / 2 + 9 * cpb;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 10; i++) drive_bit(sel, f[i], cpb);
  endtask

  task automatic drain(input string tag, input int budget);
    rec_t g, e;
    int   n;
    n = 0;
    while ((got_q.size() < exp_q.size()) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while ((got_q.size() > 0) && (exp_q.size() > 0)) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_inst"}, 32'(g.inst), 32'(e.inst));
      check({tag, "_char"}, 32'(g.val), 32'(e.val));
      check_rng({tag, "_lat"}, g.at, e.at - 1, e.at + 1);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] seq_bytes [0:8];
    logic [7:0] rb;
    int         gap, f0, r0;

    seq_bytes = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h2B, 8'h34, 8'h35, 8'h36, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    check("rst_char", 32'(char_a), 32'h0);
    check("rst_valid", 32'(cv_a), 32'h0);
    check("rst_ferr", 32'(fe_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single byte
    send(10, 8'h31, 1'b1, 1'b0);
    drain("single", 200);
    check_rng("single_busy_len", busy_fall_at - busy_rise_at, 94, 97);
    check("single_ferr", 32'(fe_cnt), 32'h0);
    $display("txn single byte 31 done");

    // Glitch of 3 cycles
    f0 = fe_cnt;
    r0 = busy_rises;
    drive_bit(1'b0, 1'b0, 3);
    drive_bit(1'b0, 1'b1, 8);
    check("glitch_busy_end", 32'(busy_a), 32'h0);
    check("glitch_busy_seen", 32'(busy_rises), 32'(r0 + 1));
    repeat (30) @(posedge clk);
    #1;
    check("glitch_no_char", 32'(got_q.size()), 32'h0);
    check("glitch_no_ferr", 32'(fe_cnt), 32'(f0));
    $display("txn glitch done");

    // Framing error then held-low line
    send(10, 8'h55, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 50);
    check("ferr_pulse", 32'(fe_cnt), 32'(f0 + 1));
    check("ferr_char_kept", 32'(char_a), 32'h31);
    check("ferr_no_char", 32'(got_q.size()), 32'h0);
    check("ferr_busy_break", 32'(busy_a), 32'h1);
    drive_bit(1'b0, 1'b1, 10);
    send(10, 8'h41, 1'b1, 1'b0);
    drain("after_ferr", 200);
    check("after_ferr_char", 32'(char_a), 32'h41);
    check("after_ferr_ferr", 32'(fe_cnt), 32'(f0 + 1));
    $display("txn frame error 55 then 41 done");

    // Reset during data bit 4 of 0xA5
    drive_bit(1'b0, 1'b0, 10);
    drive_bit(1'b0, 1'b1, 10);
    drive_bit(1'b0, 1'b0, 10);
    drive_bit(1'b0, 1'b1, 10);
    drive_bit(1'b0, 1'b0, 10);
    drive_bit(1'b0, 1'b0, 5);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_char", 32'(char_a), 32'h0);
    check("midrst_valid", 32'(cv_a), 32'h0);
    check("midrst_ferr", 32'(fe_a), 32'h0);
    check("midrst_busy", 32'(busy_a), 32'h0);
    rx_a = 1'b1;
    f0 = fe_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    check("midrst_no_char", 32'(got_q.size()), 32'h0);
    check("midrst_no_ferr", 32'(fe_cnt), 32'(f0));
    send(10, 8'h5A, 1'b1, 1'b0);
    drain("midrst_5a", 200);
    $display("txn reset mid-frame then 5A done");

    // Delimited sequence, back-to-back
    for (int k = 0; k < 9; k++) send(10, seq_bytes[k], 1'b1, 1'b0);
    drain("seq", 1200);
    $display("txn delimited sequence done");

    // Random bytes with random idle gaps
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom_range(0, 255));
      send(10, rb, 1'b1, 1'b0);
      gap = $urandom_range(0, 15);
      if (gap > 0) drive_bit(1'b0, 1'b1, gap);
    end
    drain("rand", 1200);
    check("rand_ferr", 32'(fe_cnt), 32'(f0));
    $display("txn random bytes done");

    // CPB=4 instance
    send(4, 8'hFF, 1'b1, 1'b1);
    send(4, 8'h80, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) send(4, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
    drain("cpb4", 600);
    check("cpb4_busy_idle", 32'(busy_b), 32'h0);
    check("cpb4_ferr", 32'(fe_cnt), 32'(f0));
    $display("txn cpb4 sweep done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
